// File: rtl/datamem_mmio.sv
// Word RAM plus a small memory-mapped I/O window (video, buttons, flag, timer).
// Single-cycle accept on every req, no back-pressure; rd/rvalid/err are registered one cycle later.
module datamem_mmio #(
  parameter int          DEPTH     = 64,
  parameter int          NVID      = 2,
  parameter logic [31:0] MMIO_BASE = 32'h0000f000,
  parameter bit          INV_VIDEO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [31:0]          addr,
  input  logic [31:0]          wd,
  output logic [31:0]          rd,
  output logic                 rvalid,
  output logic                 err,
  input  logic [31:0]          bs,
  input  logic                 bsf,
  output logic [NVID*32-1:0]   v
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] VID_BYTES = 32'(4 * NVID);
  localparam logic [31:0] OFF_BS    = 32'h10;
  localparam logic [31:0] OFF_FLAG  = 32'h14;
  localparam logic [31:0] OFF_TIMER = 32'h18;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_vid [NVID];
  logic [31:0] r_rd;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_timer;
  logic [31:0] r_bs_s1;
  logic [31:0] r_bs_s2;
  logic        r_bsf_s1;
  logic        r_bsf_s2;
  logic        r_bsf_d;
  logic        r_flag;

  logic [31:0] w_off;
  logic        w_aligned;
  logic        w_in_mmio;
  logic        w_ram_hit;
  logic        w_vid_hit;
  logic        w_bs_hit;
  logic        w_flag_hit;
  logic        w_timer_hit;
  logic        w_ok;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]  w_vid_idx;
  logic [31:0] w_rdata;
  logic        w_bsf_rise;

  // RAM decode takes priority so the MMIO window is only looked at above RAM.
  assign w_off       = addr - MMIO_BASE;
  assign w_aligned   = (addr[1:0] == 2'b00);
  assign w_in_mmio   = (addr >= MMIO_BASE);
  assign w_ram_hit   = (addr < RAM_BYTES);
  assign w_vid_hit   = !w_ram_hit && w_in_mmio && (w_off < VID_BYTES);
  assign w_bs_hit    = !w_ram_hit && w_in_mmio && (w_off == OFF_BS);
  assign w_flag_hit  = !w_ram_hit && w_in_mmio && (w_off == OFF_FLAG);
  assign w_timer_hit = !w_ram_hit && w_in_mmio && (w_off == OFF_TIMER);
  assign w_ok        = w_aligned &&
                       (w_ram_hit || w_vid_hit || w_bs_hit || w_flag_hit || w_timer_hit);
  assign w_rd_acc    = req && !we && w_ok;
  assign w_wr_acc    = req &&  we && w_ok;
  assign w_ram_idx   = addr[AW+1:2];
  assign w_vid_idx   = w_off[3:2];
  assign w_bsf_rise  = r_bsf_s2 && !r_bsf_d;

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) w_rdata = r_mem[w_ram_idx];
    for (int k = 0; k < NVID; k++) begin
      if (w_vid_hit && (w_vid_idx == 2'(k))) w_rdata = r_vid[k];
    end
    if (w_bs_hit)    w_rdata = r_bs_s2;
    if (w_flag_hit)  w_rdata = {31'b0, r_flag};
    if (w_timer_hit) w_rdata = r_timer;
  end

  // RAM is deliberately left without reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[w_ram_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NVID; k++) r_vid[k] <= '0;
      r_rd     <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_timer  <= '0;
      r_bs_s1  <= '0;
      r_bs_s2  <= '0;
      r_bsf_s1 <= 1'b0;
      r_bsf_s2 <= 1'b0;
      r_bsf_d  <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_timer  <= r_timer + 32'd1;
      r_bs_s1  <= bs;
      r_bs_s2  <= r_bs_s1;
      r_bsf_s1 <= bsf;
      r_bsf_s2 <= r_bsf_s1;
      r_bsf_d  <= r_bsf_s2;

      // A new edge wins over a clearing read in the same cycle.
      if (w_bsf_rise)                    r_flag <= 1'b1;
      else if (w_rd_acc && w_flag_hit)   r_flag <= 1'b0;

      if (w_wr_acc && w_vid_hit) begin
        for (int k = 0; k < NVID; k++) begin
          if (w_vid_idx == 2'(k)) begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) r_vid[k][8*b +: 8] <= wd[8*b +: 8];
            end
          end
        end
      end

      r_rvalid <= req && !we;
      r_err    <= req && !w_ok;
      if (req && !we) r_rd <= w_ok ? w_rdata : 32'h0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NVID; g++) begin : g_vid
      assign v[32*g +: 32] = INV_VIDEO ? ~r_vid[g] : r_vid[g];
    end
  endgenerate

  assign rd     = r_rd;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule
